// File: rtl/iter_div_axis_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and default width.
package iter_div_axis_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/iter_div_axis_if.sv
// Divide handshake bundle: two operand channels toward the divider, one result channel back.
interface iter_div_axis_if
  import iter_div_axis_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
);

  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;

  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tvalid,  s_axis_divisor_tdata,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tvalid,     m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid,  s_axis_divisor_tdata,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tvalid,     m_axis_dout_tdata
  );

endinterface

// File: rtl/iter_div_axis_div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend bit, trial-subtract.
module iter_div_axis_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // i_quo holds the unconsumed dividend bits above the quotient bits built so far
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_dvs};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_div_axis.sv
// Multi-cycle radix-2 restoring divider with independent operand capture slots
// and a single-cycle {quotient, remainder} result pulse.
module iter_div_axis
  import iter_div_axis_pkg::*;
#(
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned WIDTH  = DIV_W
) (
  input  logic          clk,
  input  logic          reset,
  iter_div_axis_if.slave axis
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e         r_state, w_state_nxt;
  logic               r_dvd_flag, r_dvs_flag;
  logic [WIDTH-1:0]   r_dvd, r_dvs;
  logic [WIDTH-1:0]   r_rem, r_quo, r_mag_d, r_raw_a;
  logic               r_neg_q, r_neg_r, r_dz;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_dout;

  logic               w_dvd_rdy, w_dvs_rdy, w_dvd_xfer, w_dvs_xfer, w_start, w_last;
  logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_step_rem, w_step_quo, w_q_res, w_r_res;

  assign w_dvd_rdy  = (r_state == DIV_IDLE) && !r_dvd_flag && !reset;
  assign w_dvs_rdy  = (r_state == DIV_IDLE) && !r_dvs_flag && !reset;
  assign w_dvd_xfer = axis.s_axis_dividend_tvalid && w_dvd_rdy;
  assign w_dvs_xfer = axis.s_axis_divisor_tvalid && w_dvs_rdy;

  // An operand arriving on the starting edge is used straight from the bus
  assign w_a     = r_dvd_flag ? r_dvd : axis.s_axis_dividend_tdata;
  assign w_b     = r_dvs_flag ? r_dvs : axis.s_axis_divisor_tdata;
  assign w_start = (r_state == DIV_IDLE) && (r_dvd_flag || w_dvd_xfer)
                                         && (r_dvs_flag || w_dvs_xfer);

  assign w_a_neg = SIGNED && w_a[WIDTH-1];
  assign w_b_neg = SIGNED && w_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;

  iter_div_axis_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_mag_d),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_last  = (r_count == CW'(WIDTH - 1));
  assign w_q_res = r_dz ? '1      : (r_neg_q ? -w_step_quo : w_step_quo);
  assign w_r_res = r_dz ? r_raw_a : (r_neg_r ? -w_step_rem : w_step_rem);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (w_start) w_state_nxt = DIV_CALC;
      DIV_CALC: if (w_last)  w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= DIV_IDLE;
      r_dvd_flag <= 1'b0;
      r_dvs_flag <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_mag_d    <= '0;
      r_raw_a    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_count    <= '0;
      r_dout     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dvd_xfer) begin
        r_dvd_flag <= 1'b1;
        r_dvd      <= axis.s_axis_dividend_tdata;
      end
      if (w_dvs_xfer) begin
        r_dvs_flag <= 1'b1;
        r_dvs      <= axis.s_axis_divisor_tdata;
      end
      if (r_state == DIV_DONE) begin
        r_dvd_flag <= 1'b0;
        r_dvs_flag <= 1'b0;
      end
      if (w_start) begin
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_mag_d <= w_b_mag;
        r_raw_a <= w_a;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz    <= (w_b == '0);
        r_count <= '0;
      end
      if (r_state == DIV_CALC) begin
        r_rem   <= w_step_rem;
        r_quo   <= w_step_quo;
        r_count <= r_count + 1'b1;
        if (w_last) r_dout <= {w_q_res, w_r_res};
      end
    end
  end

  assign axis.s_axis_dividend_tready = w_dvd_rdy;
  assign axis.s_axis_divisor_tready  = w_dvs_rdy;
  assign axis.m_axis_dout_tvalid     = (r_state == DIV_DONE);
  assign axis.m_axis_dout_tdata      = r_dout;

endmodule
